// File: rtl/instruction_decode_queue.sv
// ---------------------------------------------------------------------------
// instruction_decode_queue
//
// Decode stage between fetch and rename/dispatch. Each cycle it can accept one
// 32-bit instruction over a valid/ready handshake. The instruction is decoded
// combinationally into a UOP_W-bit micro-op and written into a DEPTH-entry
// circular queue. Dispatch drains the queue head over a second valid/ready
// handshake. flush_i empties the queue on a redirect.
//
// Ports
//   clk            in   1               clock, rising edge
//   rst            in   1               asynchronous active-high reset
//   flush_i        in   1               synchronous flush (highest priority)
//   instr_valid_i  in   1               fetch presents an instruction
//   instr_i        in   32              instruction word
//   instr_ready_o  out  1               queue not full (registered state only)
//   uop_valid_o    out  1               head uop valid
//   uop_o          out  UOP_W           head uop
//   uop_ready_i    in   1               dispatch consumes the head
//   count_o        out  $clog2(DEPTH)+1 occupied entries
//   undef_o        out  1               one-cycle pulse after an undefined
//                                       encoding was consumed
//
// Configuration macro: DECODE_QUEUE_BYPASS_EN
//   Defined   : an instruction arriving at an empty queue while dispatch is
//               ready goes straight to uop_o in the same cycle (combinational
//               instr_i -> uop_o path) and is not written into storage.
//   Undefined : uop_o / uop_valid_o come from registers only, 1-cycle latency.
//
// Micro-op layout (bit positions, UOP_W must be >= 44):
//   [0]      valid       [4:1]   cond        [7:5]   class
//   [8]      imm operand [11:9]  shift type  [23:12] imm12
//   [27:24]  src0 [28] src0 valid   [32:29] src1 [33] src1 valid
//   [37:34]  src2 [38] src2 valid   [42:39] dst0 [43] dst0 valid
// ---------------------------------------------------------------------------
module instruction_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int UOP_W    = 64,
  parameter int DROP_NOP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       instr_valid_i,
  input  logic [31:0]                instr_i,
  output logic                       instr_ready_o,
  output logic                       uop_valid_o,
  output logic [UOP_W-1:0]           uop_o,
  input  logic                       uop_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       undef_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Field positions of the micro-op
  localparam int UOP_VALID_B   = 0;
  localparam int UOP_COND_LSB  = 1;
  localparam int UOP_CLASS_LSB = 5;
  localparam int UOP_IMM_B     = 8;
  localparam int UOP_SHIFT_LSB = 9;
  localparam int UOP_IMM12_LSB = 12;
  localparam int UOP_SRC0_LSB  = 24;
  localparam int UOP_SRC0_V    = 28;
  localparam int UOP_SRC1_LSB  = 29;
  localparam int UOP_SRC1_V    = 33;
  localparam int UOP_SRC2_LSB  = 34;
  localparam int UOP_SRC2_V    = 38;
  localparam int UOP_DST0_LSB  = 39;
  localparam int UOP_DST0_V    = 43;

  // Class codes
  localparam logic [2:0] CLS_INTEGER   = 3'd1;
  localparam logic [2:0] CLS_INTEGER_M = 3'd2;
  localparam logic [2:0] CLS_LOAD      = 3'd3;
  localparam logic [2:0] CLS_STORE     = 3'd4;

  // Shift codes (NONE = plain register operand)
  localparam logic [2:0] SHIFT_NONE = 3'd0;
  localparam logic [2:0] SHIFT_LSL  = 3'd1;
  localparam logic [2:0] SHIFT_LSR  = 3'd2;
  localparam logic [2:0] SHIFT_ASR  = 3'd3;
  localparam logic [2:0] SHIFT_ROR  = 3'd4;

  typedef struct packed {
    logic             undef;
    logic             nop;
    logic [UOP_W-1:0] uop;
  } dec_t;

  function automatic logic [2:0] shift_code(input logic [1:0] sh);
    logic [2:0] s;
    case (sh)
      2'b00:   s = SHIFT_LSL;
      2'b01:   s = SHIFT_LSR;
      2'b10:   s = SHIFT_ASR;
      default: s = SHIFT_ROR;
    endcase
    return s;
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t       d;
    logic       has_dst;
    d.undef = 1'b0;
    d.nop   = 1'b0;
    d.uop   = '0;
    d.uop[UOP_VALID_B]           = 1'b1;
    d.uop[UOP_COND_LSB +: 4]     = i[31:28];
    // TST/TEQ/CMP/CMN (opcode 10xx) only set flags
    has_dst = (i[24:23] != 2'b10);

    if (i[27:0] == 28'h320F000) begin
      d.nop = 1'b1;
      d.uop[UOP_CLASS_LSB +: 3] = CLS_INTEGER;
    end else if (i[27:26] == 2'b00) begin
      if (!i[25] && i[7] && i[4]) begin
        d.uop[UOP_CLASS_LSB +: 3] = CLS_INTEGER_M;
        d.uop[UOP_SRC0_LSB +: 4]  = i[3:0];
        d.uop[UOP_SRC0_V]         = 1'b1;
        d.uop[UOP_SRC1_LSB +: 4]  = i[11:8];
        d.uop[UOP_SRC1_V]         = 1'b1;
        d.uop[UOP_DST0_LSB +: 4]  = i[19:16];
        d.uop[UOP_DST0_V]         = 1'b1;
        // accumulate form reads a third register
        if (i[21]) begin
          d.uop[UOP_SRC2_LSB +: 4] = i[15:12];
          d.uop[UOP_SRC2_V]        = 1'b1;
        end
      end else begin
        d.uop[UOP_SRC0_LSB +: 4] = i[19:16];
        d.uop[UOP_SRC0_V]        = 1'b1;
        if (i[25]) begin
          d.uop[UOP_CLASS_LSB +: 3]  = CLS_INTEGER;
          d.uop[UOP_IMM_B]           = 1'b1;
          d.uop[UOP_IMM12_LSB +: 12] = i[11:0];
        end else begin
          d.uop[UOP_SRC1_LSB +: 4] = i[3:0];
          d.uop[UOP_SRC1_V]        = 1'b1;
          if (!i[4]) begin
            // LSL #0 is a plain register operand and needs no shifter
            if (i[11:5] == 7'd0) begin
              d.uop[UOP_CLASS_LSB +: 3] = CLS_INTEGER;
              d.uop[UOP_SHIFT_LSB +: 3] = SHIFT_NONE;
            end else begin
              d.uop[UOP_CLASS_LSB +: 3] = CLS_INTEGER_M;
              d.uop[UOP_SHIFT_LSB +: 3] = shift_code(i[6:5]);
            end
          end else begin
            d.uop[UOP_CLASS_LSB +: 3] = (i[31:28] == 4'hE) ? CLS_INTEGER_M : CLS_INTEGER;
            d.uop[UOP_SHIFT_LSB +: 3] = shift_code(i[6:5]);
            d.uop[UOP_SRC2_LSB +: 4]  = i[11:8];
            d.uop[UOP_SRC2_V]         = 1'b1;
          end
        end
        if (has_dst) begin
          d.uop[UOP_DST0_LSB +: 4] = i[15:12];
          d.uop[UOP_DST0_V]        = 1'b1;
        end
      end
    end else if (i[27:26] == 2'b01 && !(i[25] && i[4])) begin
      // register-offset form with bit 4 set is the media/undefined space
      d.uop[UOP_CLASS_LSB +: 3] = i[20] ? CLS_LOAD : CLS_STORE;
      d.uop[UOP_SRC0_LSB +: 4]  = i[19:16];
      d.uop[UOP_SRC0_V]         = 1'b1;
      if (i[20]) begin
        d.uop[UOP_DST0_LSB +: 4] = i[15:12];
        d.uop[UOP_DST0_V]        = 1'b1;
      end
    end else begin
      d.undef = 1'b1;
    end
    return d;
  endfunction

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             undef_q;

  dec_t dec;
  logic accept;
  logic decodable;
  logic push;
  logic q_valid;
  logic pop;
  logic wr_en;
  logic bypass;

  // ---- decode / handshake (combinational) ----
  always_comb begin
    dec           = decode(instr_i);
    instr_ready_o = (count != CW'(DEPTH));
    q_valid       = (count != '0);
    accept        = instr_valid_i & instr_ready_o & ~flush_i;
    decodable     = ~dec.undef & ~(dec.nop & (DROP_NOP != 0));
    push          = accept & decodable;
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass        = ~q_valid & push & uop_ready_i;
`else
    bypass        = 1'b0;
`endif
    pop           = q_valid & uop_ready_i & ~flush_i;
    wr_en         = push & ~bypass;
  end

  // ---- queue state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      undef_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      undef_q <= 1'b0;
    end else begin
      undef_q <= accept & dec.undef;
      if (wr_en) begin
        mem[wr_ptr] <= dec.uop;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- outputs ----
  always_comb begin
    count_o     = count;
    undef_o     = undef_q;
    uop_valid_o = q_valid | bypass;
    uop_o       = bypass ? dec.uop : mem[rd_ptr];
  end

endmodule

// File: tb/tb_instruction_decode_queue.sv
module tb_instruction_decode_queue;

  localparam int DEPTH = 4;
  localparam int UOP_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic             instr_ready_o;
  logic             uop_valid_o;
  logic [UOP_W-1:0] uop_o;
  logic             uop_ready_i;
  logic [2:0]       count_o;
  logic             undef_o;

  instruction_decode_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W), .DROP_NOP(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .uop_valid_o   (uop_valid_o),
    .uop_o         (uop_o),
    .uop_ready_i   (uop_ready_i),
    .count_o       (count_o),
    .undef_o       (undef_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Build a uop from its fields
  function automatic logic [63:0] mk(input logic [3:0] cond, input logic [2:0] cls,
                                     input logic imm, input logic [2:0] sh, input logic [11:0] imm12,
                                     input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [4:0] d0);
    // sN/d0 = {valid, reg}
    logic [63:0] u;
    u = '0;
    u[0]     = 1'b1;
    u[4:1]   = cond;
    u[7:5]   = cls;
    u[8]     = imm;
    u[11:9]  = sh;
    u[23:12] = imm12;
    u[28:24] = s0;
    u[33:29] = s1;
    u[38:34] = s2;
    u[43:39] = d0;
    return u;
  endfunction

  // Reference decoder; returns 0 for encodings that are not enqueued
  function automatic logic [63:0] model(input logic [31:0] w);
    logic [3:0]  c;
    logic [4:0]  rn, rm, rs, rd, none;
    logic [2:0]  sh;
    logic        nodst;
    c    = w[31:28];
    rn   = {1'b1, w[19:16]};
    rm   = {1'b1, w[3:0]};
    rs   = {1'b1, w[11:8]};
    rd   = {1'b1, w[15:12]};
    none = 5'd0;
    sh   = 3'd1 + {1'b0, w[6:5]};
    nodst = (w[24:21] inside {4'b1000, 4'b1001, 4'b1010, 4'b1011});
    if (w[27:0] == 28'h320F000) return 64'd0;
    if (w[27:25] == 3'b000 && w[7] && w[4])
      return mk(c, 3'd2, 1'b0, 3'd0, 12'd0, rm, rs, w[21] ? rd : none, rn);
    if (w[27:25] == 3'b001)
      return mk(c, 3'd1, 1'b1, 3'd0, w[11:0], rn, none, none, nodst ? none : rd);
    if (w[27:25] == 3'b000 && !w[4] && w[11:5] == 7'd0)
      return mk(c, 3'd1, 1'b0, 3'd0, 12'd0, rn, rm, none, nodst ? none : rd);
    if (w[27:25] == 3'b000 && !w[4])
      return mk(c, 3'd2, 1'b0, sh, 12'd0, rn, rm, none, nodst ? none : rd);
    if (w[27:25] == 3'b000)
      return mk(c, (c == 4'hE) ? 3'd2 : 3'd1, 1'b0, sh, 12'd0, rn, rm, rs, nodst ? none : rd);
    if (w[27:26] == 2'b01 && !(w[25] && w[4]))
      return mk(c, w[20] ? 3'd3 : 3'd4, 1'b0, 3'd0, 12'd0, rn, none, none, w[20] ? rd : none);
    return 64'd0;
  endfunction

  // Scoreboard consumer: a pop happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && uop_valid_o && uop_ready_i && !flush_i) begin
      if (sb.size() == 0) check_eq("spurious_uop", 64'(sb.size()), 64'd1);
      else check_eq("uop_order", uop_o, sb.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] w);
    logic [63:0] e;
    int          n;
    n = 0;
    while (!instr_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check_eq("send_timeout", 64'(instr_ready_o), 64'd1);
      return;
    end
    instr_valid_i = 1'b1;
    instr_i       = w;
    e = model(w);
    if (e != 64'd0) sb.push_back(e);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    instr_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    uop_ready_i = 1'b1;
    n = 0;
    while (count_o != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check_eq("drain_count", 64'(count_o), 64'd0);
    check_eq("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] pat [10];

  initial begin
    pat = '{32'hE0010392, 32'hE0214392, 32'hE0812003, 32'hE0812103, 32'hE1A02143,
            32'hE0812315, 32'h10812315, 32'hE5912004, 32'hE5812004, 32'hE1110002};
    rst = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; uop_ready_i = 1'b0;
    #12;
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_valid", 64'(uop_valid_o), 64'd0);
    check_eq("rst_uop", uop_o, 64'd0);
    check_eq("rst_undef", 64'(undef_o), 64'd0);
    check_eq("rst_ready", 64'(instr_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // ADD immediate: one-cycle latency and field check
    uop_ready_i = 1'b1;
    send(32'hE2811005);
    check_eq("add_latency", 64'(uop_valid_o), 64'd1);
    check_eq("add_uop", uop_o, mk(4'hE, 3'd1, 1'b1, 3'd0, 12'h005, 5'h11, 5'h0, 5'h0, 5'h11));
    idle(2);

    // CMP immediate: no destination
    send(32'hE3510000);
    check_eq("cmp_dstv", 64'(uop_o[43]), 64'd0);
    check_eq("cmp_class", 64'(uop_o[7:5]), 64'd1);
    check_eq("cmp_imm", 64'(uop_o[8]), 64'd1);
    idle(2);

    // Mixed encodings back to back
    for (int k = 0; k < 10; k++) send(pat[k]);
    idle(3);
    check_eq("mix_count", 64'(count_o), 64'd0);

    // NOP dropped, undefined pulses once
    send(32'hE320F000);
    check_eq("nop_count", 64'(count_o), 64'd0);
    send(32'hE7F000F0);
    check_eq("undef_pulse", 64'(undef_o), 64'd1);
    check_eq("undef_count", 64'(count_o), 64'd0);
    idle(1);
    check_eq("undef_clear", 64'(undef_o), 64'd0);
    send(32'hEA000000);
    check_eq("branch_undef", 64'(undef_o), 64'd1);
    idle(1);

    // Fill, fifth held, pop frees a slot one cycle later
    uop_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) send(32'hE2800000 | 32'(k + 1));
    check_eq("full_count", 64'(count_o), 64'd4);
    check_eq("full_ready", 64'(instr_ready_o), 64'd0);
    instr_valid_i = 1'b1;
    instr_i       = 32'hE2800055;
    uop_ready_i   = 1'b1;
    @(posedge clk); #1;
    uop_ready_i = 1'b0;
    check_eq("full_pop_count", 64'(count_o), 64'd3);
    check_eq("full_pop_ready", 64'(instr_ready_o), 64'd1);
    sb.push_back(model(32'hE2800055));
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    check_eq("refill_count", 64'(count_o), 64'd4);
    drain();

    // Flush with simultaneous push
    uop_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) send(32'hE2811000 | 32'(k));
    instr_valid_i = 1'b1;
    instr_i       = 32'hE2822000;
    flush_i       = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; instr_valid_i = 1'b0;
    sb.delete();
    check_eq("flush_count", 64'(count_o), 64'd0);
    check_eq("flush_valid", 64'(uop_valid_o), 64'd0);
    check_eq("flush_ready", 64'(instr_ready_o), 64'd1);
    idle(1);
    check_eq("flush_undef", 64'(undef_o), 64'd0);

    // Pointer wrap: 10 simultaneous push/pop pairs at occupancy 2
    send(32'hE2833001);
    send(32'hE2833002);
    uop_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(32'hE2844000 | 32'(k + 16));
      check_eq("wrap_count", 64'(count_o), 64'd2);
    end
    drain();

    // Asynchronous reset between edges
    uop_ready_i = 1'b0;
    send(32'hE2855001);
    send(32'hE2855002);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_count", 64'(count_o), 64'd0);
    check_eq("arst_valid", 64'(uop_valid_o), 64'd0);
    check_eq("arst_uop", uop_o, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

`ifdef DECODE_QUEUE_BYPASS_EN
    // Empty queue and ready dispatch: same-cycle uop
    uop_ready_i   = 1'b1;
    instr_valid_i = 1'b1;
    instr_i       = 32'hE2811005;
    sb.push_back(model(32'hE2811005));
    #1;
    check_eq("bypass_valid", 64'(uop_valid_o), 64'd1);
    check_eq("bypass_uop", uop_o, model(32'hE2811005));
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    check_eq("bypass_count", 64'(count_o), 64'd0);
    idle(1);
`endif

    check_eq("final_sb", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
